// File: rtl/trigger_sequencer.sv
// rtl/trigger_sequencer.sv - decimating arm/warm-up/holdoff trigger sequencer for minmax_filter
// Optional debounce qualification: define TRIGGER_SEQ_DEBOUNCE_EN.
module trigger_sequencer #(
  parameter int SAMPLE_DATA_WIDTH = 8,
  parameter int DECIMATE          = 200,
  parameter int WARMUP_SAMPLES    = 500,
  parameter int HOLDOFF_SAMPLES   = 1000,
  parameter int TIMESTAMP_WIDTH   = 32,
  parameter int DEBOUNCE_SAMPLES  = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                adc_axiiv,
  input  logic signed [SAMPLE_DATA_WIDTH-1:0] adc_axiid,
  input  logic                                arm,
  input  logic                                continuous,
  input  logic                                abort,
  output logic                                filter_rst,
  output logic                                filter_axiiv,
  output logic signed [SAMPLE_DATA_WIDTH-1:0] filter_axiid,
  input  logic                                filter_triggered,
  output logic                                event_valid,
  output logic [TIMESTAMP_WIDTH-1:0]          event_timestamp,
  output logic [1:0]                          state
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_WARMUP  = 2'd1;
  localparam logic [1:0] S_ARMED   = 2'd2;
  localparam logic [1:0] S_HOLDOFF = 2'd3;

  localparam int DEC_W = (DECIMATE > 1) ? $clog2(DECIMATE) : 1;
  localparam logic [DEC_W-1:0] DEC_LAST = DEC_W'(DECIMATE - 1);
  localparam logic [31:0] WARM_LAST = 32'(WARMUP_SAMPLES - 1);
  localparam logic [31:0] HOLD_LAST = 32'(HOLDOFF_SAMPLES - 1);

  if (DECIMATE < 1) begin : g_bad_decimate
    $error("DECIMATE must be >= 1");
  end
  if (DEBOUNCE_SAMPLES < 1) begin : g_bad_debounce
    $error("DEBOUNCE_SAMPLES must be >= 1");
  end

  logic [DEC_W-1:0]           dec_cnt;
  logic [31:0]                cnt;
  logic [TIMESTAMP_WIDTH-1:0] ts;
  logic                       cont_q;
  logic                       trig_prev;
  logic                       fwd;
  logic                       qual;
  logic                       warm_done;
  logic                       hold_done;
  logic [1:0]                 state_nxt;

  assign fwd       = adc_axiiv && (dec_cnt == '0) && (state != S_IDLE);
  assign warm_done = (WARMUP_SAMPLES == 0) || (fwd && (cnt == WARM_LAST));
  assign hold_done = (HOLDOFF_SAMPLES == 0) || (fwd && (cnt == HOLD_LAST));

`ifdef TRIGGER_SEQ_DEBOUNCE_EN
  localparam logic [31:0] DEB_LAST = 32'(DEBOUNCE_SAMPLES - 1);

  logic [31:0] deb_cnt;
  logic        armed_low;
  logic        deb_elig;

  // A high that was already present on entry to ARMED only counts once it has been seen low.
  assign deb_elig = filter_triggered && ((deb_cnt != '0) || armed_low || !trig_prev);
  assign qual     = (state == S_ARMED) && fwd && deb_elig && (deb_cnt == DEB_LAST);

  always_ff @(posedge clk) begin
    if (rst || (state != S_ARMED)) begin
      deb_cnt   <= '0;
      armed_low <= 1'b0;
    end else begin
      if (!filter_triggered) armed_low <= 1'b1;
      if (fwd) begin
        if (!filter_triggered) deb_cnt <= '0;
        else if (deb_elig)     deb_cnt <= deb_cnt + 32'd1;
      end
    end
  end
`else
  assign qual = (state == S_ARMED) && filter_triggered && !trig_prev;
`endif

  always_comb begin
    state_nxt = state;
    if (abort) begin
      state_nxt = S_IDLE;
    end else begin
      case (state)
        S_IDLE:   if (arm)       state_nxt = S_WARMUP;
        S_WARMUP: if (warm_done) state_nxt = S_ARMED;
        S_ARMED:  if (qual)      state_nxt = cont_q ? S_HOLDOFF : S_IDLE;
        default:  if (hold_done) state_nxt = S_ARMED;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      filter_rst      <= 1'b1;
      filter_axiiv    <= 1'b0;
      filter_axiid    <= '0;
      event_valid     <= 1'b0;
      event_timestamp <= '0;
      dec_cnt         <= '0;
      cnt             <= '0;
      ts              <= '0;
      cont_q          <= 1'b0;
      trig_prev       <= 1'b0;
    end else begin
      state        <= state_nxt;
      filter_rst   <= (state_nxt == S_IDLE);
      filter_axiiv <= fwd;
      if (fwd) filter_axiid <= adc_axiid;

      event_valid <= qual && !abort;
      if (qual && !abort) event_timestamp <= ts;

      trig_prev <= (state != S_IDLE) && filter_triggered;

      if ((state == S_IDLE) || (state_nxt == S_IDLE)) dec_cnt <= '0;
      else if (adc_axiiv) dec_cnt <= (dec_cnt == DEC_LAST) ? '0 : dec_cnt + 1'b1;

      if (state == S_IDLE) begin
        if (arm && !abort) begin
          cont_q <= continuous;
          ts     <= '0;
        end
      end else if (fwd && (ts != '1)) begin
        ts <= ts + 1'b1;
      end

      // The warm-up and holdoff phases share one forwarded-sample counter, restarted on every state change.
      if (state != state_nxt) cnt <= '0;
      else if (fwd)           cnt <= cnt + 32'd1;
    end
  end

endmodule

// File: tb/tb_trigger_sequencer.sv
// tb/tb_trigger_sequencer.sv - directed bench for trigger_sequencer with a sample-count reference model
// Define TRIGGER_SEQ_DEBOUNCE_EN for the debounce scenario.
module tb_trigger_sequencer;
  localparam int W    = 8;
  localparam int DEC  = 4;
  localparam int WARM = 8;
  localparam int HOLD = 5;
  localparam int TSW  = 16;
  localparam int DEB  = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                rst, adc_axiiv, arm, continuous, abort, filter_triggered;
  logic signed [W-1:0] adc_axiid;
  logic                filter_rst, filter_axiiv, event_valid;
  logic signed [W-1:0] filter_axiid;
  logic [TSW-1:0]      event_timestamp;
  logic [1:0]          state;

  int n_vec = 0;
  int n_err = 0;

  trigger_sequencer #(
    .SAMPLE_DATA_WIDTH(W), .DECIMATE(DEC), .WARMUP_SAMPLES(WARM),
    .HOLDOFF_SAMPLES(HOLD), .TIMESTAMP_WIDTH(TSW), .DEBOUNCE_SAMPLES(DEB)
  ) dut (
    .clk(clk), .rst(rst), .adc_axiiv(adc_axiiv), .adc_axiid(adc_axiid),
    .arm(arm), .continuous(continuous), .abort(abort),
    .filter_rst(filter_rst), .filter_axiiv(filter_axiiv), .filter_axiid(filter_axiid),
    .filter_triggered(filter_triggered), .event_valid(event_valid),
    .event_timestamp(event_timestamp), .state(state)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phases are judged by how many samples were forwarded since arm / since holdoff entry.
  int m_state, m_fwd, m_beats, m_hold0, m_run;
  bit m_cont, m_prev, m_low, m_on;
  int e_state, e_fd, e_ets;
  bit e_frst, e_fv, e_ev;

  always @(posedge clk) begin : model
    bit fwd, q, elig;
    int nxt, ts;
    if (rst) begin
      m_state = 0; m_fwd = 0; m_beats = 0; m_hold0 = 0; m_run = 0;
      m_cont = 0; m_prev = 0; m_low = 0; m_on = 1;
      e_state = 0; e_frst = 1; e_fv = 0; e_fd = 0; e_ev = 0; e_ets = 0;
    end else begin
      ts   = (m_fwd > 65535) ? 65535 : m_fwd;
      fwd  = (m_state != 0) && adc_axiiv && (m_beats % DEC == 0);
      elig = filter_triggered && (m_run > 0 || m_low || !m_prev);
`ifdef TRIGGER_SEQ_DEBOUNCE_EN
      q = (m_state == 2) && fwd && elig && (m_run + 1 >= DEB);
`else
      q = (m_state == 2) && filter_triggered && !m_prev;
`endif
      e_fv = fwd;
      if (fwd) e_fd = int'(adc_axiid);
      e_ev = q && !abort;
      if (e_ev) e_ets = ts;
      nxt = m_state;
      if (abort) nxt = 0;
      else case (m_state)
        0: if (arm) nxt = 1;
        1: if (m_fwd + int'(fwd) >= WARM) nxt = 2;
        2: if (q) nxt = m_cont ? 3 : 0;
        default: if (m_fwd + int'(fwd) - m_hold0 >= HOLD) nxt = 2;
      endcase
      if (nxt != 2) begin
        m_run = 0; m_low = 0;
      end else if (m_state == 2) begin
        if (!filter_triggered) m_low = 1;
        if (fwd) m_run = !filter_triggered ? 0 : (elig ? m_run + 1 : m_run);
      end
      m_prev = (m_state != 0) && filter_triggered;
      if (m_state != 0) begin
        m_fwd = m_fwd + int'(fwd);
        if (adc_axiiv) m_beats++;
      end
      if (m_state == 0 && nxt == 1) begin
        m_fwd = 0; m_beats = 0; m_cont = continuous;
      end
      if (m_state == 2 && nxt == 3) m_hold0 = m_fwd;
      m_state = nxt;
      e_state = nxt;
      e_frst  = (nxt == 0);
    end
  end

  always @(negedge clk) begin
    if (m_on) begin
      check("state", 32'(state), 32'(e_state));
      check("filter_rst", 32'(filter_rst), 32'(e_frst));
      check("filter_axiiv", 32'(filter_axiiv), 32'(e_fv));
      check("filter_axiid", 32'(int'(filter_axiid)), 32'(e_fd));
      check("event_valid", 32'(event_valid), 32'(e_ev));
      check("event_timestamp", 32'(event_timestamp), 32'(e_ets));
    end
  end

  task automatic cyc(input logic t, input logic a, input logic ab, input logic c);
    filter_triggered = t; arm = a; abort = ab; continuous = c;
    @(posedge clk); #1;
    adc_axiid = adc_axiid + 8'sd1;
  endtask

  initial begin
    rst = 1; adc_axiiv = 1; adc_axiid = '0; arm = 0; continuous = 0; abort = 0; filter_triggered = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_state", 32'(state), 0);
    check("rst_filter_rst", 32'(filter_rst), 1);
    check("rst_filter_axiiv", 32'(filter_axiiv), 0);
    check("rst_event_valid", 32'(event_valid), 0);
    check("rst_event_ts", 32'(event_timestamp), 0);
    rst = 0;
    cyc(0, 0, 0, 0);
    check("idle_filter_rst", 32'(filter_rst), 1);

`ifndef TRIGGER_SEQ_DEBOUNCE_EN
    // One-shot: ramp decimation, masked warm-up pulse, event at ts 18.
    cyc(0, 1, 0, 0);
    adc_axiid = '0;
    check("s1_arm_state", 32'(state), 1);
    check("s1_arm_filter_rst", 32'(filter_rst), 0);
    for (int i = 0; i < 72; i++) begin
      cyc((i >= 10 && i < 14) || i >= 69, 0, 0, 0);
      if (i <= 28 && i % 4 == 0) begin
        check("s1_fwd_valid", 32'(filter_axiiv), 1);
        check("s1_fwd_data", 32'(int'(filter_axiid)), 32'(i));
      end
      if (i == 27) check("s1_still_warmup", 32'(state), 1);
      if (i == 28) check("s1_armed", 32'(state), 2);
      if (i == 14) check("s1_warm_masked", 32'(event_valid), 0);
      if (i == 69) begin
        check("s1_event", 32'(event_valid), 1);
        check("s1_event_ts", 32'(event_timestamp), 18);
        check("s1_idle", 32'(state), 0);
        check("s1_filter_rst", 32'(filter_rst), 1);
      end
      if (i == 70) check("s1_single_pulse", 32'(event_valid), 0);
    end

    // Continuous: events at ts 12 and 20, rise during holdoff ignored.
    cyc(0, 1, 0, 1);
    adc_axiid = '0;
    for (int j = 0; j < 85; j++) begin
      cyc(j == 45 || j == 53 || j == 54 || (j >= 77 && j <= 79), 0, 0, 1);
      if (j == 45) begin
        check("s2_event1", 32'(event_valid), 1);
        check("s2_event1_ts", 32'(event_timestamp), 12);
        check("s2_holdoff", 32'(state), 3);
      end
      if (j == 53) check("s2_holdoff_masked", 32'(event_valid), 0);
      if (j == 63) check("s2_holdoff_end_minus1", 32'(state), 3);
      if (j == 64) check("s2_rearmed", 32'(state), 2);
      if (j == 77) begin
        check("s2_event2", 32'(event_valid), 1);
        check("s2_event2_ts", 32'(event_timestamp), 20);
      end
    end
    cyc(0, 0, 1, 1);
    check("s2_abort_idle", 32'(state), 0);
    check("s2_ts_held", 32'(event_timestamp), 20);

    // arm during WARMUP is ignored: warm-up length and ts carry on.
    cyc(0, 1, 0, 0);
    adc_axiid = '0;
    for (int k = 0; k < 36; k++) begin
      cyc(k == 33, k == 10, 0, 0);
      if (k == 27) check("s3_warmup", 32'(state), 1);
      if (k == 28) check("s3_armed", 32'(state), 2);
      if (k == 33) begin
        check("s3_event", 32'(event_valid), 1);
        check("s3_event_ts", 32'(event_timestamp), 9);
      end
    end

    // abort beats a same-cycle qualified trigger.
    cyc(0, 1, 0, 0);
    adc_axiid = '0;
    for (int k = 0; k < 36; k++) begin
      cyc(k == 33, 0, k == 33, 0);
      if (k == 33) begin
        check("s4_abort_state", 32'(state), 0);
        check("s4_abort_no_event", 32'(event_valid), 0);
        check("s4_abort_ts_held", 32'(event_timestamp), 9);
      end
    end
`else
    // Debounce: 3 high beats then low -> nothing; 4 high beats -> event at the 4th.
    cyc(0, 1, 0, 0);
    adc_axiid = '0;
    for (int i = 0; i < 66; i++) begin
      cyc((i >= 30 && i <= 41) || (i >= 46 && i <= 62), 0, 0, 0);
      if (i == 28) check("d_armed", 32'(state), 2);
      if (i == 40 || i == 44) check("d_short_run", 32'(event_valid), 0);
      if (i == 60) begin
        check("d_event", 32'(event_valid), 1);
        check("d_event_ts", 32'(event_timestamp), 15);
        check("d_idle", 32'(state), 0);
      end
    end
`endif

    // Reset in the middle of warm-up.
    cyc(0, 1, 0, 0);
    for (int k = 0; k < 10; k++) cyc(0, 0, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    check("mid_rst_state", 32'(state), 0);
    check("mid_rst_filter_rst", 32'(filter_rst), 1);
    check("mid_rst_event_ts", 32'(event_timestamp), 0);
    rst = 0;
    cyc(0, 0, 0, 0);
    cyc(0, 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/trigger_sequencer.md
Name: trigger_sequencer

Overview:
- Controls the minmax_filter keyup detector: decimates the raw ADC sample stream into the filter, holds the filter in reset while idle, and masks triggers during a warm-up window until the filter's look-back history is valid.
- Turns filter trigger rising edges into timestamped single-cycle events, then applies a holdoff before re-arming.
- Sits between the ADC/AXI-lite-style sample stream and the minmax_filter instance. Feeds the capture/logging logic downstream.

Parameters:
- SAMPLE_DATA_WIDTH, 8: sample width in bits; signed.
- DECIMATE, 200: forward 1 of every DECIMATE input beats (2 MSPS to 10 kSps). Must be >= 1.
- WARMUP_SAMPLES, 500: forwarded samples before triggers are honoured. Set equal to the filter LOOK_BACK.
- HOLDOFF_SAMPLES, 1000: forwarded samples ignored after an event in continuous mode. May be 0.
- TIMESTAMP_WIDTH, 32: width of the forwarded-sample timestamp.
- DEBOUNCE_SAMPLES, 4: used only with TRIGGER_SEQ_DEBOUNCE_EN.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- adc_axiiv  in  1  input sample valid.
- adc_axiid  in  SAMPLE_DATA_WIDTH  input sample, signed.
- arm  in  1  single-cycle start request; honoured only in IDLE.
- continuous  in  1  sampled with arm. 1 = re-arm after holdoff; 0 = one-shot.
- abort  in  1  return to IDLE.
- filter_rst  out  1  reset to minmax_filter.
- filter_axiiv  out  1  decimated sample valid to the filter.
- filter_axiid  out  SAMPLE_DATA_WIDTH  decimated sample to the filter.
- filter_triggered  in  1  trigger level from the filter.
- event_valid  out  1  single-cycle event pulse.
- event_timestamp  out  TIMESTAMP_WIDTH  forwarded-sample count at the event.
- state  out  2  state encoding: 0 IDLE, 1 WARMUP, 2 ARMED, 3 HOLDOFF.

Behaviour:
- Reset values:
  - state = IDLE; filter_rst = 1.
  - filter_axiiv, filter_axiid, event_valid, event_timestamp = 0.
  - All counters = 0; trig_prev = 0.
- Outputs are registered. filter_rst = 1 exactly while state is IDLE.
- Decimation:
  - dec_cnt counts adc_axiiv beats modulo DECIMATE. It is held at 0 in IDLE.
  - A beat is forwarded when dec_cnt == 0 and state != IDLE.
  - Forwarded beat: filter_axiiv = 1 and filter_axiid = adc_axiid one cycle later (latency 1, single-cycle pulse). DECIMATE = 1 forwards every beat.
- Timestamp:
  - ts increments on each forwarded sample. It is cleared on arm and saturates at all-ones.
- trig_prev:
  - Updated each cycle from filter_triggered while state != IDLE.
  - Forced to 0 in IDLE.
- IDLE:
  - arm = 1 gives next cycle WARMUP, latches continuous, clears ts, warm counter and dec_cnt.
  - An adc beat in the arm cycle is not forwarded.
- WARMUP:
  - Counts forwarded samples; triggers are ignored.
  - When the count reaches WARMUP_SAMPLES, go to ARMED in the cycle after the last forwarded beat.
  - WARMUP_SAMPLES = 0 goes to ARMED the cycle after entry.
- ARMED:
  - A qualified trigger (filter_triggered = 1 and trig_prev = 0) gives event_valid = 1 next cycle and event_timestamp = ts at the detection cycle.
  - Next state is HOLDOFF if continuous was latched, otherwise IDLE.
  - A trigger already high on entry to ARMED does not fire; it must fall and rise again.
- HOLDOFF:
  - Counts forwarded samples from 0 and returns to ARMED after HOLDOFF_SAMPLES.
  - HOLDOFF_SAMPLES = 0 returns to ARMED the next cycle.
  - Triggers are ignored.
- event_timestamp holds its value until the next event.
- arm outside IDLE is ignored.
- Priority: rst > abort > trigger/arm/count transitions.
  - abort in any state gives IDLE next cycle with no event, even if a qualified trigger occurs in the same cycle.
  - An in-flight filter_axiiv already registered still completes.
- Reset mid-operation returns all reset values next cycle.

Optional Feature:
- TRIGGER_SEQ_DEBOUNCE_EN defined:
  - A trigger qualifies only after filter_triggered has been high on DEBOUNCE_SAMPLES consecutive forwarded beats while ARMED, with the count starting from a low-to-high transition.
  - event_timestamp = ts at the qualifying beat.
  - A low on any forwarded beat clears the count.
- TRIGGER_SEQ_DEBOUNCE_EN undefined: rising-edge qualification as in Behaviour; DEBOUNCE_SAMPLES is unused.

Test Plan:
Bench uses DECIMATE=4, WARMUP=8, HOLDOFF=5, TIMESTAMP_WIDTH=16, a stub filter driven by the bench, and ADC beats every cycle.
- Decimation: arm, continuous=0, data ramp 0,1,2... gives filter_axiiv pulses every 4 cycles carrying 0,4,8,...; filter_rst drops the cycle after arm; state reaches ARMED after the 8th forwarded beat.
- Warm-up masking: triggered pulsed high during WARMUP, low again before ARMED -> no event_valid; state remains 1 then 2.
- One-shot event: after 10 forwarded samples in ARMED, triggered rises -> one event_valid pulse, event_timestamp = 18, state goes to 0, filter_rst goes to 1.
- Continuous holdoff: continuous=1; trigger at ts=12, second rise at ts=14 and third at ts=20 -> events only at ts 12 and 20; HOLDOFF spans 5 forwarded samples.
- Abort/priority: abort in the same cycle as a triggered rise in ARMED -> no event, IDLE next cycle. arm during WARMUP -> ts not cleared.
- Debounce (macro defined, DEBOUNCE=4): triggered high for 3 forwarded beats then low -> no event; then high for 4 beats -> one event at the 4th beat.
